processing_cell_eager: RTL
==========================

Name: processing_cell_eager

Overview:
Parametrised next-generation CGRA processing cell. It selects two operands from NUM_PORTS neighbour inputs or a configured constant, and buffers each operand in a FIFO of depth FIFO_DEPTH. It joins the operands, executes one ALU op (optionally accumulating over N iterations) and registers the result. An eager fork then delivers the result independently to every masked neighbour. It replaces the fixed 4-port cell, whose lazy fork needs all consumers ready in the same cycle.

Parameters:
DATA_WIDTH, 32, datapath width (>=8).
NUM_PORTS, 4, neighbour input/output channels (2..8).
FIFO_DEPTH, 2, per-operand FIFO entries (power of two, >=2).
SW (localparam), $clog2(NUM_PORTS+1), operand select width.
CFG_WIDTH (localparam), 2*SW+NUM_PORTS+4+1+16+DATA_WIDTH.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
din  in  NUM_PORTS*DATA_WIDTH  neighbour data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
din_v  in  NUM_PORTS  neighbour valids
din_1_r  out  1  operand-1 FIFO ready (= not full)
din_2_r  out  1  operand-2 FIFO ready (= not full)
dout  out  DATA_WIDTH  result register
dout_v  out  NUM_PORTS  per-destination valid
dout_r  in  NUM_PORTS  per-destination ready
config_bits  in  CFG_WIDTH  static config, LSB first: sel_1[SW], sel_2[SW], fork_mask[NUM_PORTS], op[4], feedback[1], iterations[16], const[DATA_WIDTH]

Behaviour:
- Reset: FIFOs empty; dout=0; dout_v=0; pending mask=0; iteration counter=0; accumulator=const. config_bits is held stable while rst is low.
- Operand select:
  - sel<NUM_PORTS picks port sel.
  - sel==NUM_PORTS picks const, always valid.
  - sel>NUM_PORTS: operand never valid.
- FIFO push when selected valid && !full.
- FIFO ready = !full, independent of a same-cycle pop.
- A written entry is visible at the head on the next cycle.
- Fire condition: head1 valid && (feedback || head2 valid) && output stage free.
- On fire: pop head1, and pop head2 when feedback=0. In feedback mode FIFO2 is never popped.
- Output stage free when pending==0, or when every remaining pending bit handshakes this cycle. Back-to-back fires therefore give full throughput.
- ALU (a=head1; b=head2, or accumulator when feedback=1):
  - 0 add, 1 sub a-b, 2 mul low DATA_WIDTH bits, 3 and, 4 or, 5 xor.
  - 6 sll, 7 srl, 8 sra; shift amount is b[$clog2(DATA_WIDTH)-1:0].
  - 9 pass a, 10 signed slt (result 1/0), 11 signed min, 12 signed max.
  - 13-15 result 0.
  - All arithmetic wraps modulo 2^DATA_WIDTH.
- Non-feedback: every fire loads dout=result and pending=fork_mask.
- Feedback: each fire sets accumulator=result and increments the counter. When counter+1 reaches iterations (0 treated as 1):
  - load dout and pending as above;
  - reload accumulator=const;
  - clear counter.
  - Intermediate results are not emitted.
- Eager fork:
  - dout_v[i] = pending[i].
  - A handshake on i (dout_v[i]&&dout_r[i]) clears pending[i].
  - Each destination sees each result exactly once.
  - dout_v never depends combinationally on dout_r. dout is held while any pending bit is set.
- fork_mask=0: fire still occurs, the result is discarded, and the stage is always free.
- Latency: input accepted at cycle t → fire at t+1 → dout_v at t+2.
- Reset mid-operation: FIFO contents, partial accumulation and undelivered results are lost; outputs return to reset values on the next edge.

Optional Feature:
PE_FIRE_CNT_EN: when defined, adds output port fire_cnt [31:0]. It counts fires, cleared by rst and wrapping 0xFFFFFFFF→0. When undefined, the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
1. sel_1=0, sel_2=1, op=0, mask=0b0001. Port0=5, port1=7 valid at cycle 0 → dout=12, dout_v=0001 at cycle 2, cleared after dout_r[0].
2. Eager fork, mask=0b1111, result 3:
   - dout_r=0001 at c0, 0110 at c1, 1000 at c2.
   - Each bit drops on its handshake; a new result loads at c2 with no bubble.
3. Backpressure, FIFO_DEPTH=2, dout_r=0, 4 pairs offered:
   - din_1_r falls after FIFO full (2 entries + 1 in output stage).
   - Releasing dout_r delivers all 4 results in order with no loss or duplicates.
4. feedback=1, op=0, const=0, iterations=4, sel_1=0, inputs 1,2,3,4 → single output 10; next 4 inputs 1 each → 4.
5. sel_2=NUM_PORTS, const=0xFFFFFFFF, op=6, a=1 → dout=0x80000000. Same with op=8, a=0x80000000 → 0xFFFFFFFF.
6. Assert rst with one result pending and both FIFOs full → next cycle dout_v=0, din_1_r=din_2_r=1, and no stale result ever appears.

Source files
------------

// File: rtl/processing_cell_eager.sv
// CGRA processing cell: operand select, per-operand FIFOs, join, ALU with optional
// accumulation and an eager per-destination fork. `PE_FIRE_CNT_EN adds a fire counter port.
module pe_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;

  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign head_o  = mem_q[rp_q];

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + 1'b1;
      if (pop_i)  rp_q <= rp_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// One destination of the eager fork: holds its pending bit until its own handshake.
module pe_fork_lane (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic mask_i,
  input  logic rdy_i,
  output logic pend_o
);
  logic pend_q, pend_d;

  always_comb begin
    pend_d = pend_q & ~rdy_i;
    if (load_i) pend_d = mask_i;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= pend_d;
  end

  assign pend_o = pend_q;
endmodule

module processing_cell_eager #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 2,
  localparam int SW        = $clog2(NUM_PORTS+1),
  localparam int CFG_WIDTH = 2*SW+NUM_PORTS+4+1+16+DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] din,
  input  logic [NUM_PORTS-1:0]            din_v,
  output logic                            din_1_r,
  output logic                            din_2_r,
  output logic [DATA_WIDTH-1:0]           dout,
  output logic [NUM_PORTS-1:0]            dout_v,
  input  logic [NUM_PORTS-1:0]            dout_r,
  input  logic [CFG_WIDTH-1:0]            config_bits
`ifdef PE_FIRE_CNT_EN
  ,
  output logic [31:0]                     fire_cnt
`endif
);
  localparam int DW  = DATA_WIDTH;
  localparam int NP  = NUM_PORTS;
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int OM  = 2*SW;
  localparam int OO  = OM + NP;
  localparam int OF  = OO + 4;
  localparam int OI  = OF + 1;
  localparam int OC  = OI + 16;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
  } opnd_t;

  logic [SW-1:0] sel_1, sel_2;
  logic [NP-1:0] fork_mask;
  logic [3:0]    op;
  logic          feedback;
  logic [15:0]   iterations;
  logic [DW-1:0] cst;

  assign sel_1      = config_bits[0 +: SW];
  assign sel_2      = config_bits[SW +: SW];
  assign fork_mask  = config_bits[OM +: NP];
  assign op         = config_bits[OO +: 4];
  assign feedback   = config_bits[OF];
  assign iterations = config_bits[OI +: 16];
  assign cst        = config_bits[OC +: DW];

  logic [NP-1:0][DW-1:0] din_a;
  assign din_a = din;

  // Out-of-range selects never produce a valid operand.
  function automatic opnd_t pick(input logic [SW-1:0] s, input logic [NP-1:0] dv,
                                 input logic [NP-1:0][DW-1:0] da, input logic [DW-1:0] c);
    opnd_t o;
    o.v = (s == SW'(NP));
    o.d = c;
    for (int k = 0; k < NP; k++) begin
      if (s == SW'(k)) begin
        o.v = dv[k];
        o.d = da[k];
      end
    end
    return o;
  endfunction

  opnd_t op1, op2;
  assign op1 = pick(sel_1, din_v, din_a, cst);
  assign op2 = pick(sel_2, din_v, din_a, cst);

  logic          full1, full2, empty1, empty2, push1, push2, pop1, pop2;
  logic [DW-1:0] head1, head2;

  assign push1   = op1.v & ~full1;
  assign push2   = op2.v & ~full2;
  assign din_1_r = ~full1;
  assign din_2_r = ~full2;

  pe_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .rst(rst), .push_i(push1), .pop_i(pop1), .din_i(op1.d),
    .full_o(full1), .empty_o(empty1), .head_o(head1)
  );
  pe_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_fifo2 (
    .clk(clk), .rst(rst), .push_i(push2), .pop_i(pop2), .din_i(op2.d),
    .full_o(full2), .empty_o(empty2), .head_o(head2)
  );

  logic [NP-1:0] pend;
  logic          free, fire, emit, last;
  logic [DW-1:0] acc_q, acc_d, dout_q, dout_d, a, b, res;
  logic [15:0]   cnt_q, cnt_d, it_eff;
  logic [16:0]   cnt_nx;
  logic [SHW-1:0] sh;

  // Free also when every still-pending destination completes this very cycle.
  assign free = ~|(pend & ~dout_r);
  assign fire = ~empty1 & (feedback | ~empty2) & free;
  assign pop1 = fire;
  assign pop2 = fire & ~feedback;

  assign a  = head1;
  assign b  = feedback ? acc_q : head2;
  assign sh = b[SHW-1:0];

  always_comb begin
    res = '0;
    case (op)
      4'd0:    res = a + b;
      4'd1:    res = a - b;
      4'd2:    res = a * b;
      4'd3:    res = a & b;
      4'd4:    res = a | b;
      4'd5:    res = a ^ b;
      4'd6:    res = a << sh;
      4'd7:    res = a >> sh;
      4'd8:    res = $signed(a) >>> sh;
      4'd9:    res = a;
      4'd10:   res = {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
      4'd11:   res = ($signed(a) < $signed(b)) ? a : b;
      4'd12:   res = ($signed(a) < $signed(b)) ? b : a;
      default: res = '0;
    endcase
  end

  assign it_eff = (iterations == '0) ? 16'd1 : iterations;
  assign cnt_nx = {1'b0, cnt_q} + 17'd1;
  assign last   = cnt_nx == {1'b0, it_eff};
  assign emit   = fire & (~feedback | last);

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (fire && feedback) begin
      if (last) begin
        acc_d = cst;
        cnt_d = '0;
      end else begin
        acc_d = res;
        cnt_d = cnt_nx[15:0];
      end
    end
    if (emit) dout_d = res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= cst;
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  for (genvar i = 0; i < NP; i++) begin : g_lane
    pe_fork_lane u_lane (
      .clk(clk), .rst(rst), .load_i(emit), .mask_i(fork_mask[i]),
      .rdy_i(dout_r[i]), .pend_o(pend[i])
    );
  end

  assign dout   = dout_q;
  assign dout_v = pend;

`ifdef PE_FIRE_CNT_EN
  logic [31:0] fire_cnt_q;
  always_ff @(posedge clk) begin
    if (rst)       fire_cnt_q <= '0;
    else if (fire) fire_cnt_q <= fire_cnt_q + 32'd1;
  end
  assign fire_cnt = fire_cnt_q;
`endif
endmodule
